// File: rtl/mul_arb.sv
// mul_arb: round-robin arbiter and sequencer that shares one pipelined
// 27x27 multiplier between two requesters. It tags each issued operation with
// the requester id, then routes the product back with a registered valid pulse.
module mul_arb #(
  parameter int LAT = 2,
  parameter int CW  = $clog2(LAT + 2)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic [26:0]   a0,
  input  logic [26:0]   b0,
  output logic          gnt0,
  input  logic          req1,
  input  logic [26:0]   a1,
  input  logic [26:0]   b1,
  output logic          gnt1,
  output logic          mul_en,
  output logic [26:0]   mul_in_1,
  output logic [26:0]   mul_in_2,
  input  logic [53:0]   mul_out,
  output logic          rsp_vld0,
  output logic          rsp_vld1,
  output logic [53:0]   rsp_data,
  output logic          busy
);

  // Round-robin pointer: requester that wins when both ask.
  logic          prio;

  // Tag pipeline, one {valid, id} pair per multiplier stage.
  logic [LAT-1:0] tag_vld;
  logic [LAT-1:0] tag_id;

  // Outstanding operations per requester.
  logic [CW-1:0] cnt0, cnt1;
  logic [CW-1:0] cnt0_nxt, cnt1_nxt;

  logic          ret_vld;
  logic          ret_id;

  assign ret_vld = tag_vld[LAT-1];
  assign ret_id  = tag_id[LAT-1];

  // Grant selection: a lone request wins, a tie goes to the pointer.
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0 && req1) begin
      if (prio) gnt1 = 1'b1;
      else      gnt0 = 1'b1;
    end else if (req0) begin
      gnt0 = 1'b1;
    end else if (req1) begin
      gnt1 = 1'b1;
    end
  end

  assign mul_en   = gnt0 | gnt1;
  assign mul_in_1 = gnt0 ? a0 : (gnt1 ? a1 : '0);
  assign mul_in_2 = gnt0 ? b0 : (gnt1 ? b1 : '0);

  // Pointer moves to the loser after every grant, holds when idle.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio <= 1'b0;
    end else if (gnt0) begin
      prio <= 1'b1;
    end else if (gnt1) begin
      prio <= 1'b0;
    end
  end

  // Tag shift register tracking the multiplier pipeline; never stalls.
  // NOTE: the tag stages are reset (unlike a plain data pipeline) because a
  // stale valid bit after reset would fire a spurious response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_vld <= '0;
      tag_id  <= '0;
    end else begin
      tag_vld[0] <= mul_en;
      tag_id[0]  <= gnt1;
      for (int i = 1; i < LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_id[i]  <= tag_id[i-1];
      end
    end
  end

  // Retire: capture the product and pulse the owner's valid for one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_vld0 <= 1'b0;
      rsp_vld1 <= 1'b0;
      rsp_data <= '0;
    end else if (ret_vld) begin
      rsp_data <= mul_out;
      rsp_vld0 <= ~ret_id;
      rsp_vld1 <= ret_id;
    end else begin
      rsp_vld0 <= 1'b0;
      rsp_vld1 <= 1'b0;
    end
  end

  // Counter update: +1 on grant, -1 while the response pulse is out.
  always_comb begin
    cnt0_nxt = cnt0;
    cnt1_nxt = cnt1;
    case ({gnt0, rsp_vld0})
      2'b10:   cnt0_nxt = cnt0 + CW'(1);
      2'b01:   cnt0_nxt = cnt0 - CW'(1);
      default: cnt0_nxt = cnt0;
    endcase
    case ({gnt1, rsp_vld1})
      2'b10:   cnt1_nxt = cnt1 + CW'(1);
      2'b01:   cnt1_nxt = cnt1 - CW'(1);
      default: cnt1_nxt = cnt1;
    endcase
  end

  // Counter and busy registers; busy mirrors the registered counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt0 <= '0;
      cnt1 <= '0;
      busy <= 1'b0;
    end else begin
      cnt0 <= cnt0_nxt;
      cnt1 <= cnt1_nxt;
      busy <= (cnt0_nxt != '0) || (cnt1_nxt != '0);
    end
  end

endmodule

// File: tb/tb_mul_arb.sv
// tb_mul_arb: table-driven checks of mul_arb against a behavioural
// LAT-stage multiplier, plus hand-written latency and async-reset sequences.
module tb_mul_arb;
  localparam int LAT = 2;
  localparam logic [26:0] MX = 27'h7FFFFFF;
  localparam logic [53:0] MXP = 54'h3FFFFFF0000001;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [26:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic        gnt0, gnt1, mul_en;
  logic [26:0] mul_in_1, mul_in_2;
  logic [53:0] mul_out;
  logic        rsp_vld0, rsp_vld1;
  logic [53:0] rsp_data;
  logic        busy;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  mul_arb #(.LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .a0(a0), .b0(b0), .gnt0(gnt0),
    .req1(req1), .a1(a1), .b1(b1), .gnt1(gnt1),
    .mul_en(mul_en), .mul_in_1(mul_in_1), .mul_in_2(mul_in_2),
    .mul_out(mul_out),
    .rsp_vld0(rsp_vld0), .rsp_vld1(rsp_vld1), .rsp_data(rsp_data),
    .busy(busy)
  );

  // Behavioural multiplier: product appears LAT cycles after issue, not reset.
  logic [53:0] mpipe [LAT];
  always @(posedge clk) begin
    mpipe[0] <= 54'(mul_in_1) * 54'(mul_in_2);
    for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_out = mpipe[LAT-1];

  typedef struct {
    logic        rst;
    logic        r0;
    logic [26:0] a0, b0;
    logic        r1;
    logic [26:0] a1, b1;
    logic        g0, g1;
    logic [26:0] m1, m2;
    logic        v0, v1;
    logic [53:0] d;
    logic        bz;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_v(input logic r0_, input logic [26:0] a0_, input logic [26:0] b0_,
                       input logic r1_, input logic [26:0] a1_, input logic [26:0] b1_,
                       input logic g0_, input logic g1_,
                       input logic [26:0] m1_, input logic [26:0] m2_,
                       input logic v0_, input logic v1_, input logic [53:0] d_, input logic bz_);
    vec_t v;
    v.rst = 1'b1; v.r0 = r0_; v.a0 = a0_; v.b0 = b0_; v.r1 = r1_; v.a1 = a1_; v.b1 = b1_;
    v.g0 = g0_; v.g1 = g1_; v.m1 = m1_; v.m2 = m2_; v.v0 = v0_; v.v1 = v1_; v.d = d_; v.bz = bz_;
    vecs.push_back(v);
  endtask

  task automatic add_idle(input logic v0_, input logic v1_, input logic [53:0] d_, input logic bz_);
    add_v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, v0_, v1_, d_, bz_);
  endtask

  // Reset held low for this cycle: everything reads zero.
  task automatic add_rst();
    vec_t v;
    add_idle(0, 0, 0, 0);
    v = vecs.pop_back();
    v.rst = 1'b0;
    vecs.push_back(v);
  endtask

  task automatic drive_idle();
    req0 = 1'b0; req1 = 1'b0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seen;

    // Single op: 3*5 returns in cycle 3, busy cycles 1-3.
    add_rst();
    add_v(1, 3, 5, 0, 0, 0, 1, 0, 3, 5, 0, 0, 0, 0);
    add_idle(0, 0, 0, 1);
    add_idle(0, 0, 0, 1);
    add_idle(1, 0, 15, 1);
    add_idle(0, 0, 15, 0);

    // Contention: grants 0,1,0,1 then a lone 0; responses in issue order.
    add_rst();
    add_v(1, 2, 3,   1, 4, 5, 1, 0, 2, 3,   0, 0, 0, 0);
    add_v(1, 6, 7,   1, 4, 5, 0, 1, 4, 5,   0, 0, 0, 1);
    add_v(1, 6, 7,   1, 8, 9, 1, 0, 6, 7,   0, 0, 0, 1);
    add_v(1, 10, 11, 1, 8, 9, 0, 1, 8, 9,   1, 0, 6, 1);
    add_v(1, 10, 11, 0, 0, 0, 1, 0, 10, 11, 0, 1, 20, 1);
    add_idle(1, 0, 42, 1);
    add_idle(0, 1, 72, 1);
    add_idle(1, 0, 110, 1);
    add_idle(0, 0, 110, 0);

    // Back-to-back single requester: counter reaches LAT+1.
    add_rst();
    add_v(0, 0, 0, 1, 1, 1, 0, 1, 1, 1, 0, 0, 0, 0);
    add_v(0, 0, 0, 1, 2, 1, 0, 1, 2, 1, 0, 0, 0, 1);
    add_v(0, 0, 0, 1, 3, 1, 0, 1, 3, 1, 0, 0, 0, 1);
    add_v(0, 0, 0, 1, 4, 1, 0, 1, 4, 1, 0, 1, 1, 1);
    add_v(0, 0, 0, 1, 5, 1, 0, 1, 5, 1, 0, 1, 2, 1);
    add_idle(0, 1, 3, 1);
    add_idle(0, 1, 4, 1);
    add_idle(0, 1, 5, 1);
    add_idle(0, 0, 5, 0);

    // Max operands.
    add_rst();
    add_v(1, MX, MX, 0, 0, 0, 1, 0, MX, MX, 0, 0, 0, 0);
    add_idle(0, 0, 0, 1);
    add_idle(0, 0, 0, 1);
    add_idle(1, 0, MXP, 1);
    add_idle(0, 0, MXP, 0);

    // Reset mid-flight: in-flight op never responds.
    add_rst();
    add_v(1, 3, 5, 0, 0, 0, 1, 0, 3, 5, 0, 0, 0, 0);
    add_rst();
    add_rst();
    add_idle(0, 0, 0, 0);
    add_idle(0, 0, 0, 0);
    add_idle(0, 0, 0, 0);
    add_idle(0, 0, 0, 0);

    // Idle pointer hold: after granting 0 and idling, a tie goes to 1.
    add_rst();
    add_v(1, 1, 1, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0);
    add_idle(0, 0, 0, 1);
    add_idle(0, 0, 0, 1);
    add_idle(1, 0, 1, 1);
    add_v(1, 2, 2, 1, 3, 3, 0, 1, 3, 3, 0, 0, 1, 0);
    add_v(1, 2, 2, 0, 0, 0, 1, 0, 2, 2, 0, 0, 1, 1);
    add_idle(0, 0, 1, 1);
    add_idle(0, 1, 9, 1);
    add_idle(1, 0, 4, 1);
    add_idle(0, 0, 4, 0);

    // Apply each row: drive 1 time unit after the edge, sample 1 unit later.
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      reset = vecs[i].rst;
      req0 = vecs[i].r0; a0 = vecs[i].a0; b0 = vecs[i].b0;
      req1 = vecs[i].r1; a1 = vecs[i].a1; b1 = vecs[i].b1;
      #1;
      check($sformatf("gnt0 row%0d", i),     64'(gnt0),     64'(vecs[i].g0));
      check($sformatf("gnt1 row%0d", i),     64'(gnt1),     64'(vecs[i].g1));
      check($sformatf("mul_en row%0d", i),   64'(mul_en),   64'(vecs[i].g0 | vecs[i].g1));
      check($sformatf("mul_in_1 row%0d", i), 64'(mul_in_1), 64'(vecs[i].m1));
      check($sformatf("mul_in_2 row%0d", i), 64'(mul_in_2), 64'(vecs[i].m2));
      check($sformatf("rsp_vld0 row%0d", i), 64'(rsp_vld0), 64'(vecs[i].v0));
      check($sformatf("rsp_vld1 row%0d", i), 64'(rsp_vld1), 64'(vecs[i].v1));
      check($sformatf("rsp_data row%0d", i), 64'(rsp_data), 64'(vecs[i].d));
      check($sformatf("busy row%0d", i),     64'(busy),     64'(vecs[i].bz));
    end

    // Latency: a single issue from requester 1 must answer LAT+1 cycles later.
    @(posedge clk); #1; reset = 1'b0; drive_idle();
    @(posedge clk); #1; reset = 1'b1;
    req1 = 1'b1; a1 = 27'd123; b1 = 27'd456;
    #1;
    check("lat gnt1", 64'(gnt1), 64'd1);
    @(posedge clk); #1; drive_idle(); #1;
    n = 1;
    while (!rsp_vld1 && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    check("lat cycles", 64'(n), 64'(LAT + 1));
    check("lat data", 64'(rsp_data), 64'd56088);
    check("lat vld0 quiet", 64'(rsp_vld0), 64'd0);

    // Async reset asserted in the middle of a cycle clears busy at once.
    @(posedge clk); #1;
    req0 = 1'b1; a0 = 27'd7; b0 = 27'd9;
    @(posedge clk); #1; drive_idle(); #1;
    check("async busy before", 64'(busy), 64'd1);
    #2; reset = 1'b0; #1;
    check("async busy after", 64'(busy), 64'd0);
    check("async vld0 after", 64'(rsp_vld0), 64'd0);
    @(posedge clk); #1; reset = 1'b1;
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #2;
      if (rsp_vld0 || rsp_vld1 || busy) seen++;
    end
    check("async no response", 64'(seen), 64'd0);
    check("async data cleared", 64'(rsp_data), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
